// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo core.
// Holds the reorder-buffer geometry, the per-entry life-cycle state and the
// packed entry record used by tomasulo_rob.
package tomasulo_pkg;

    localparam int ROB_ENTRIES = 8;   // ROB depth, power of two
    localparam int ROB_TAG_W   = 3;   // log2(ROB_ENTRIES)
    localparam int REG_W       = 4;   // architectural register index width
    localparam int DATA_W      = 16;  // result data width

    // FREE: unallocated; BUSY: allocated, waiting for its CDB result;
    // DONE: result captured, waiting to retire in program order.
    typedef enum logic [1:0] {
        FREE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } rob_state_t;

    typedef struct packed {
        rob_state_t             state;
        logic [REG_W-1:0]       dest;
        logic [DATA_W-1:0]      value;
    } rob_entry_t;

endpackage

// File: rtl/tomasulo_rob_if.sv
// Issue / CDB / lookup / commit bus of the reorder buffer.
//   master : issue stage, CDB arbiter and register bank side
//   slave  : the reorder buffer itself
//
// Handshake: an allocation is accepted on a rising edge where
// alloc_valid && alloc_ready; alloc_tag is the tag granted by that edge.
// alloc_ready depends only on the ROB occupancy, never on alloc_valid.
// cdb_valid and commit_valid are single-cycle pulses with no back-pressure.
interface tomasulo_rob_if;
    import tomasulo_pkg::*;

    logic                     alloc_valid;
    logic [REG_W-1:0]         alloc_dest;
    logic                     alloc_ready;
    logic [ROB_TAG_W-1:0]     alloc_tag;

    logic                     cdb_valid;
    logic [ROB_TAG_W-1:0]     cdb_tag;
    logic [DATA_W-1:0]        cdb_data;

    logic [ROB_TAG_W-1:0]     rd_tag;
    logic                     rd_ready;
    logic [DATA_W-1:0]        rd_data;

    logic                     commit_valid;
    logic [REG_W-1:0]         commit_dest;
    logic [DATA_W-1:0]        commit_data;
    logic [ROB_TAG_W-1:0]     commit_tag;

    logic [ROB_TAG_W:0]       count;

    modport master (
        output alloc_valid, alloc_dest, cdb_valid, cdb_tag, cdb_data, rd_tag,
        input  alloc_ready, alloc_tag, rd_ready, rd_data,
        input  commit_valid, commit_dest, commit_data, commit_tag, count
    );

    modport slave (
        input  alloc_valid, alloc_dest, cdb_valid, cdb_tag, cdb_data, rd_tag,
        output alloc_ready, alloc_tag, rd_ready, rd_data,
        output commit_valid, commit_dest, commit_data, commit_tag, count
    );

endinterface

// File: rtl/tomasulo_rob.sv
// Eight-entry reorder buffer.
// Allocates entries in program order for the issue stage, captures results
// from the common data bus, forwards completed values back to issue and
// retires entries in order to the register bank.
// Ports:
//   clk1  - clock, all state changes on the rising edge
//   reset - synchronous active-high reset
//   flush - synchronous clear of every in-flight entry (same effect as reset)
//   bus   - tomasulo_rob_if.slave: alloc, CDB, lookup, commit and count
module tomasulo_rob
    import tomasulo_pkg::*;
(
    input  logic           clk1,
    input  logic           reset,
    input  logic           flush,
    tomasulo_rob_if.slave  bus
);

    localparam int                CNT_W    = ROB_TAG_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(ROB_ENTRIES);

    rob_entry_t               entries [ROB_ENTRIES];
    logic [ROB_TAG_W-1:0]     head_p;
    logic [ROB_TAG_W-1:0]     tail_p;
    logic [CNT_W-1:0]         count_q;

    logic                     commit_valid_q;
    logic [REG_W-1:0]         commit_dest_q;
    logic [DATA_W-1:0]        commit_data_q;
    logic [ROB_TAG_W-1:0]     commit_tag_q;

    logic                     alloc_ready_c;
    logic                     alloc_fire;
    logic                     cdb_fire;
    logic                     commit_fire;
    logic                     rd_ready_c;
    logic [DATA_W-1:0]        rd_data_c;

    // Alloc targets a FREE tail entry, the CDB only writes BUSY entries and
    // commit only takes a DONE head, so the three never touch the same entry.
    // alloc_ready deliberately ignores a same-cycle commit.
    always_comb begin
        alloc_ready_c = (count_q != FULL_CNT);
        alloc_fire    = bus.alloc_valid && alloc_ready_c;
        cdb_fire      = bus.cdb_valid && (entries[bus.cdb_tag].state == BUSY);
        commit_fire   = (entries[head_p].state == DONE);
    end

    // Operand lookup; a BUSY entry whose result is on the CDB right now is
    // forwarded straight from the bus.
    always_comb begin
        rd_ready_c = 1'b0;
        rd_data_c  = '0;
        if (entries[bus.rd_tag].state == DONE) begin
            rd_ready_c = 1'b1;
            rd_data_c  = entries[bus.rd_tag].value;
        end else if (entries[bus.rd_tag].state == BUSY && bus.cdb_valid &&
                     bus.cdb_tag == bus.rd_tag) begin
            rd_ready_c = 1'b1;
            rd_data_c  = bus.cdb_data;
        end
    end

    always_ff @(posedge clk1) begin
        if (reset || flush) begin
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                entries[i] <= '0;
            end
            head_p         <= '0;
            tail_p         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_dest_q  <= '0;
            commit_data_q  <= '0;
            commit_tag_q   <= '0;
        end else begin
            if (alloc_fire) begin
                entries[tail_p].state <= BUSY;
                entries[tail_p].dest  <= bus.alloc_dest;
                tail_p                <= tail_p + ROB_TAG_W'(1);
            end
            if (cdb_fire) begin
                entries[bus.cdb_tag].state <= DONE;
                entries[bus.cdb_tag].value <= bus.cdb_data;
            end
            commit_valid_q <= commit_fire;
            if (commit_fire) begin
                commit_dest_q         <= entries[head_p].dest;
                commit_data_q         <= entries[head_p].value;
                commit_tag_q          <= head_p;
                entries[head_p].state <= FREE;
                head_p                <= head_p + ROB_TAG_W'(1);
            end
            count_q <= count_q + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
        end
    end

    assign bus.alloc_ready  = alloc_ready_c;
    assign bus.alloc_tag    = tail_p;
    assign bus.rd_ready     = rd_ready_c;
    assign bus.rd_data      = rd_data_c;
    assign bus.commit_valid = commit_valid_q;
    assign bus.commit_dest  = commit_dest_q;
    assign bus.commit_data  = commit_data_q;
    assign bus.commit_tag   = commit_tag_q;
    assign bus.count        = count_q;

endmodule

// File: tb/tb_tomasulo_rob.sv
// Self-checking bench for tomasulo_rob.
// Inputs change on the falling edge and outputs are sampled on the falling
// edge, half a cycle away from the rising edge that updates the ROB.
// Every allocation pushes {tag, dest, planned result} onto exp_q; the commit
// monitor pops one record per commit pulse and compares all three fields.
module tb_tomasulo_rob;
    import tomasulo_pkg::*;

    logic clk1 = 1'b0;
    logic reset;
    logic flush;

    always #5 clk1 = ~clk1;

    tomasulo_rob_if rob_bus ();

    tomasulo_rob dut (
        .clk1  (clk1),
        .reset (reset),
        .flush (flush),
        .bus   (rob_bus)
    );

    int checks = 0;
    int errors = 0;

    logic [22:0]          exp_q[$];   // {tag[2:0], dest[3:0], data[15:0]}
    logic [ROB_TAG_W-1:0] m_tail;     // model of the next granted tag

    // ---------------- scoreboard: commit monitor ----------------
    always @(negedge clk1) begin
        logic [22:0] exp_rec;
        if (rob_bus.commit_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL commit_unexpected: got tag %0d dest %0d data %h, expected no commit",
                         rob_bus.commit_tag, rob_bus.commit_dest, rob_bus.commit_data);
            end else begin
                exp_rec = exp_q.pop_front();
                if ({rob_bus.commit_tag, rob_bus.commit_dest, rob_bus.commit_data} !== exp_rec) begin
                    errors++;
                    $display("FAIL commit_fields: got tag %0d dest %0d data %h, expected tag %0d dest %0d data %h",
                             rob_bus.commit_tag, rob_bus.commit_dest, rob_bus.commit_data,
                             exp_rec[22:20], exp_rec[19:16], exp_rec[15:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk1);
    endtask

    task automatic idle_inputs();
        rob_bus.alloc_valid = 1'b0;
        rob_bus.alloc_dest  = '0;
        rob_bus.cdb_valid   = 1'b0;
        rob_bus.cdb_tag     = '0;
        rob_bus.cdb_data    = '0;
        rob_bus.rd_tag      = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk1);
        idle_inputs();
        flush = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        m_tail = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Called on a falling edge; returns on the falling edge after the
    // allocation edge.
    task automatic drive_alloc(input logic [REG_W-1:0] dest, input logic [DATA_W-1:0] data);
        rob_bus.alloc_valid = 1'b1;
        rob_bus.alloc_dest  = dest;
        #1;
        checks++;
        if (rob_bus.alloc_ready !== 1'b1 || rob_bus.alloc_tag !== m_tail) begin
            errors++;
            $display("FAIL alloc_grant: got ready %b tag %0d, expected ready 1 tag %0d",
                     rob_bus.alloc_ready, rob_bus.alloc_tag, m_tail);
        end
        exp_q.push_back({m_tail, dest, data});
        m_tail = m_tail + 3'd1;
        tick();
        rob_bus.alloc_valid = 1'b0;
    endtask

    task automatic drive_cdb(input logic [ROB_TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        rob_bus.cdb_valid = 1'b1;
        rob_bus.cdb_tag   = tag;
        rob_bus.cdb_data  = data;
        tick();
        rob_bus.cdb_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d commits outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic check_count(input string name, input logic [ROB_TAG_W:0] exp_cnt);
        checks++;
        if (rob_bus.count !== exp_cnt) begin
            errors++;
            $display("FAIL %s: got count %0d, expected %0d", name, rob_bus.count, exp_cnt);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        rob_bus.rd_tag = 3'd0;
        #1;
        checks++;
        if (rob_bus.count !== 4'd0 || rob_bus.alloc_ready !== 1'b1 || rob_bus.alloc_tag !== 3'd0) begin
            errors++;
            $display("FAIL reset_alloc: got count %0d ready %b tag %0d, expected 0 1 0",
                     rob_bus.count, rob_bus.alloc_ready, rob_bus.alloc_tag);
        end
        checks++;
        if (rob_bus.rd_ready !== 1'b0 || rob_bus.rd_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_lookup: got ready %b data %h, expected 0 0000",
                     rob_bus.rd_ready, rob_bus.rd_data);
        end
        checks++;
        if ({rob_bus.commit_valid, rob_bus.commit_dest, rob_bus.commit_data, rob_bus.commit_tag} !== 24'h0) begin
            errors++;
            $display("FAIL reset_commit: got valid %b dest %0d data %h tag %0d, expected all 0",
                     rob_bus.commit_valid, rob_bus.commit_dest, rob_bus.commit_data, rob_bus.commit_tag);
        end
    endtask

    task automatic test_single();
        apply_reset();
        drive_alloc(4'd5, 16'h00AA);
        drive_cdb(3'd0, 16'h00AA);
        checks++;
        if (rob_bus.commit_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got commit_valid %b, expected 0", rob_bus.commit_valid);
        end
        tick();
        checks++;
        if ({rob_bus.commit_valid, rob_bus.commit_tag, rob_bus.commit_dest, rob_bus.commit_data} !==
            {1'b1, 3'd0, 4'd5, 16'h00AA}) begin
            errors++;
            $display("FAIL single_commit: got valid %b tag %0d dest %0d data %h, expected 1 0 5 00aa",
                     rob_bus.commit_valid, rob_bus.commit_tag, rob_bus.commit_dest, rob_bus.commit_data);
        end
        check_count("single_count", 4'd0);
    endtask

    task automatic test_out_of_order();
        apply_reset();
        for (int i = 0; i < 3; i++) drive_alloc(4'(i + 1), 16'h0100 + 16'(i));
        for (int i = 2; i >= 0; i--) begin
            drive_cdb(3'(i), 16'h0100 + 16'(i));
            checks++;
            if (rob_bus.commit_valid !== 1'b0) begin
                errors++;
                $display("FAIL ooo_hold_%0d: got commit_valid %b, expected 0", i, rob_bus.commit_valid);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rob_bus.commit_valid !== 1'b1 || rob_bus.commit_tag !== 3'(i)) begin
                errors++;
                $display("FAIL ooo_order_%0d: got valid %b tag %0d, expected 1 %0d",
                         i, rob_bus.commit_valid, rob_bus.commit_tag, i);
            end
        end
        tick();
        check_count("ooo_count", 4'd0);
    endtask

    task automatic test_full_wrap();
        apply_reset();
        for (int i = 0; i < 8; i++) drive_alloc(4'(i), 16'h0200 + 16'(i));
        #1;
        check_count("full_count", 4'd8);
        checks++;
        if (rob_bus.alloc_ready !== 1'b0 || rob_bus.alloc_tag !== 3'd0) begin
            errors++;
            $display("FAIL full_ready: got ready %b tag %0d, expected 0 0", rob_bus.alloc_ready, rob_bus.alloc_tag);
        end
        // Request while full, completing the head in the same cycle.
        rob_bus.alloc_valid = 1'b1;
        rob_bus.alloc_dest  = 4'd9;
        drive_cdb(3'd0, 16'h0200);
        #1;
        checks++;
        if (rob_bus.alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_no_credit: got ready %b, expected 0", rob_bus.alloc_ready);
        end
        check_count("full_hold", 4'd8);
        tick();
        rob_bus.alloc_valid = 1'b0;
        check_count("full_after_commit", 4'd7);
        drive_alloc(4'd9, 16'h02FF);
        check_count("full_refill", 4'd8);
        for (int t = 1; t < 8; t++) drive_cdb(3'(t), 16'h0200 + 16'(t));
        drive_cdb(3'd0, 16'h02FF);
        drain(20);
        check_count("full_drained", 4'd0);
    endtask

    task automatic test_bypass();
        apply_reset();
        drive_alloc(4'd1, 16'h0300);
        drive_alloc(4'd2, 16'h0301);
        drive_alloc(4'd3, 16'h0302);
        drive_alloc(4'd4, 16'h1234);
        rob_bus.rd_tag = 3'd3;
        #1;
        checks++;
        if (rob_bus.rd_ready !== 1'b0 || rob_bus.rd_data !== 16'h0) begin
            errors++;
            $display("FAIL bypass_busy: got ready %b data %h, expected 0 0000", rob_bus.rd_ready, rob_bus.rd_data);
        end
        rob_bus.cdb_valid = 1'b1;
        rob_bus.cdb_tag   = 3'd2;
        rob_bus.cdb_data  = 16'h0302;
        #1;
        checks++;
        if (rob_bus.rd_ready !== 1'b0) begin
            errors++;
            $display("FAIL bypass_other_tag: got ready %b, expected 0", rob_bus.rd_ready);
        end
        rob_bus.cdb_tag  = 3'd3;
        rob_bus.cdb_data = 16'h1234;
        #1;
        checks++;
        if (rob_bus.rd_ready !== 1'b1 || rob_bus.rd_data !== 16'h1234) begin
            errors++;
            $display("FAIL bypass_cdb: got ready %b data %h, expected 1 1234", rob_bus.rd_ready, rob_bus.rd_data);
        end
        tick();
        rob_bus.cdb_valid = 1'b0;
        #1;
        checks++;
        if (rob_bus.rd_ready !== 1'b1 || rob_bus.rd_data !== 16'h1234) begin
            errors++;
            $display("FAIL lookup_done: got ready %b data %h, expected 1 1234", rob_bus.rd_ready, rob_bus.rd_data);
        end
        drive_cdb(3'd3, 16'hBEEF);
        #1;
        checks++;
        if (rob_bus.rd_data !== 16'h1234) begin
            errors++;
            $display("FAIL no_overwrite: got data %h, expected 1234", rob_bus.rd_data);
        end
        // CDB write to a FREE entry must be dropped.
        rob_bus.rd_tag = 3'd5;
        rob_bus.cdb_valid = 1'b1;
        rob_bus.cdb_tag   = 3'd5;
        rob_bus.cdb_data  = 16'h5555;
        #1;
        checks++;
        if (rob_bus.rd_ready !== 1'b0 || rob_bus.rd_data !== 16'h0) begin
            errors++;
            $display("FAIL free_lookup: got ready %b data %h, expected 0 0000", rob_bus.rd_ready, rob_bus.rd_data);
        end
        tick();
        rob_bus.cdb_valid = 1'b0;
        check_count("free_write_count", 4'd4);
        for (int i = 0; i < 3; i++) drive_cdb(3'(i), 16'h0300 + 16'(i));
        drain(20);
        drive_alloc(4'd6, 16'h0444);
        drive_alloc(4'd7, 16'h0555);
        #1;
        checks++;
        if (rob_bus.rd_ready !== 1'b0) begin
            errors++;
            $display("FAIL free_write_ignored: got ready %b for tag 5, expected 0", rob_bus.rd_ready);
        end
        drive_cdb(3'd4, 16'h0444);
        drive_cdb(3'd5, 16'h0555);
        drain(20);
    endtask

    task automatic test_flush(input bit use_reset);
        string nm;
        nm = use_reset ? "reset_mid" : "flush_mid";
        apply_reset();
        // Leave non-zero commit outputs behind before the clear.
        drive_alloc(4'd8, 16'h04FF);
        drive_cdb(3'd0, 16'h04FF);
        drain(10);
        for (int i = 0; i < 4; i++) drive_alloc(4'(9 + i), 16'h0400 + 16'(i));
        drive_cdb(3'd2, 16'h0401);
        drive_cdb(3'd1, 16'h0400);
        // Head (tag 1) is DONE: it would retire on the next edge.
        if (use_reset) reset = 1'b1;
        else flush = 1'b1;
        rob_bus.alloc_valid = 1'b1;
        rob_bus.alloc_dest  = 4'd15;
        rob_bus.cdb_valid   = 1'b1;
        rob_bus.cdb_tag     = 3'd3;
        rob_bus.cdb_data    = 16'hDEAD;
        exp_q.delete();
        m_tail = '0;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        idle_inputs();
        rob_bus.rd_tag = 3'd2;
        #1;
        checks++;
        if ({rob_bus.commit_valid, rob_bus.commit_dest, rob_bus.commit_data, rob_bus.commit_tag} !== 24'h0) begin
            errors++;
            $display("FAIL %s_commit: got valid %b dest %0d data %h tag %0d, expected all 0", nm,
                     rob_bus.commit_valid, rob_bus.commit_dest, rob_bus.commit_data, rob_bus.commit_tag);
        end
        check_count({nm, "_count"}, 4'd0);
        checks++;
        if (rob_bus.alloc_tag !== 3'd0 || rob_bus.alloc_ready !== 1'b1 || rob_bus.rd_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_state: got tag %0d ready %b rd_ready %b, expected 0 1 0", nm,
                     rob_bus.alloc_tag, rob_bus.alloc_ready, rob_bus.rd_ready);
        end
        drive_alloc(4'd7, 16'h04AA);
        drive_cdb(3'd0, 16'h04AA);
        drain(10);
    endtask

    task automatic test_back_to_back();
        logic [ROB_TAG_W-1:0] prev_tag;
        logic [DATA_W-1:0]    prev_data;
        logic [REG_W-1:0]     dest;
        logic [DATA_W-1:0]    data;
        apply_reset();
        prev_tag  = '0;
        prev_data = '0;
        for (int k = 0; k < 12; k++) begin
            dest = 4'($urandom_range(0, 15));
            data = 16'($urandom_range(0, 65535));
            rob_bus.alloc_valid = 1'b1;
            rob_bus.alloc_dest  = dest;
            rob_bus.cdb_valid   = (k > 0);
            rob_bus.cdb_tag     = prev_tag;
            rob_bus.cdb_data    = prev_data;
            #1;
            checks++;
            if (rob_bus.alloc_ready !== 1'b1 || rob_bus.alloc_tag !== m_tail) begin
                errors++;
                $display("FAIL b2b_grant_%0d: got ready %b tag %0d, expected 1 %0d",
                         k, rob_bus.alloc_ready, rob_bus.alloc_tag, m_tail);
            end
            exp_q.push_back({m_tail, dest, data});
            prev_tag  = m_tail;
            prev_data = data;
            m_tail    = m_tail + 3'd1;
            tick();
        end
        idle_inputs();
        check_count("b2b_steady_count", 4'd2);
        checks++;
        if (rob_bus.commit_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_throughput: got commit_valid %b, expected 1", rob_bus.commit_valid);
        end
        drive_cdb(prev_tag, prev_data);
        drain(20);
        check_count("b2b_drained", 4'd0);
    endtask

    // ---------------- sequence ----------------
    initial begin
        reset = 1'b1;
        flush = 1'b0;
        idle_inputs();
        m_tail = '0;
        test_reset();
        test_single();
        test_out_of_order();
        test_full_wrap();
        test_bypass();
        test_flush(1'b0);
        test_flush(1'b1);
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of sequence by 200000, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tomasulo_rob.md
# tomasulo_rob

Eight-entry reorder buffer for the Tomasulo core. Sits downstream of the add/mul reservation stations: it consumes their results from the common data bus (CDB) and retires them in program order to the register bank. Issue allocates an entry per instruction and receives its tag. Issue can also read back completed-but-uncommitted values for operand forwarding.

## Interface
- `ENTRIES`, 8: ROB depth; power of two.
- `TAG_W`, 3: log2(ENTRIES); ROB tag width.
- `REG_W`, 4: architectural register index width (16 registers).
- `DATA_W`, 16: result data width.

Ports:
- `clk1` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: synchronous clear of all in-flight entries.
- `alloc_valid` in 1: issue requests an entry.
- `alloc_dest` in REG_W: destination register of the issuing instruction.
- `alloc_ready` out 1: combinational; `count != ENTRIES`.
- `alloc_tag` out TAG_W: combinational; equals `tail_p`, the tag granted if the allocation is accepted.
- `cdb_valid` in 1: result broadcast.
- `cdb_tag` in TAG_W: tag of the broadcast result.
- `cdb_data` in DATA_W: result value.
- `rd_tag` in TAG_W: operand lookup tag from issue.
- `rd_ready` out 1: combinational; the looked-up value is available.
- `rd_data` out DATA_W: combinational lookup value.
- `commit_valid` out 1: registered retire pulse.
- `commit_dest` out REG_W: registered; destination register of the retiring entry.
- `commit_data` out DATA_W: registered; value of the retiring entry.
- `commit_tag` out TAG_W: registered; tag of the retiring entry.
- `count` out TAG_W+1: occupied entries, 0..ENTRIES.

## Operation
- Each entry holds `state`, `dest` and `value`. `state` is one of FREE, BUSY or DONE.
- `head_p` and `tail_p` are TAG_W bits wide and wrap modulo ENTRIES. Full and empty are distinguished only by `count`.
- **Allocate.** Accepted when `alloc_valid && alloc_ready`.
  - `entry[tail_p]` becomes BUSY and `dest` is set to `alloc_dest`.
  - `tail_p` increments.
- **CDB write.** When `cdb_valid` and `entry[cdb_tag]` is BUSY, the entry's `value` is set to `cdb_data` and it becomes DONE.
  - A CDB write to a FREE or DONE entry is ignored; there is no overwrite.
- **Commit.** When `entry[head_p]` is DONE, the entry retires:
  - `commit_*` outputs are loaded from the entry and `commit_valid` is set to 1;
  - the entry becomes FREE and `head_p` increments.
  - Otherwise `commit_valid` is 0 and the other `commit_*` outputs hold their last values.
  - At most one commit per cycle.
- **Lookup.**
  - `entry[rd_tag]` is DONE: `rd_ready` = 1, `rd_data` = `value`.
  - `entry[rd_tag]` is BUSY and `cdb_valid && cdb_tag == rd_tag`: `rd_ready` = 1, `rd_data` = `cdb_data` (bypass).
  - Otherwise `rd_ready` = 0 and `rd_data` = 0.
- **count** is updated as `count + accepted_alloc - commit`.
- Allocate, CDB write and commit may all occur on the same edge, to different entries, and all take effect.
- `alloc_ready` does not credit a same-cycle commit. When full, allocation stalls one cycle even if the head retires that edge.
- **Priority:** `reset` > `flush` > normal operation.
- **Flush** has the same effect as reset on all ROB state and outputs: every entry FREE, pointers 0, `count` 0, `commit_valid` 0. Any allocate, CDB write or commit presented on the flush edge is discarded.

## Timing
- **Reset values:**
  - `head_p` = `tail_p` = 0, `count` = 0, all entries FREE.
  - `commit_valid` = 0, `commit_dest` = 0, `commit_data` = 0, `commit_tag` = 0.
  - `alloc_ready` = 1, `alloc_tag` = 0, `rd_ready` = 0, `rd_data` = 0.
- Reset asserted mid-operation discards all entries on that edge, including any pending commit.
- **Allocate to CDB:** a tag allocated at edge N may be written by the CDB at edge N+1 at the earliest.
- **CDB to commit:** a result written at edge N, if at head, commits at edge N+1. `commit_valid` is high for the cycle following N+1.
- Sustained throughput: one allocation and one commit per cycle.
- Lookup is zero-latency and combinational.

## Structure
- Shared package `tomasulo_pkg` holds:
  - constants `ROB_ENTRIES`, `ROB_TAG_W`, `REG_W`, `DATA_W`;
  - enum `rob_state_t` {FREE, BUSY, DONE};
  - packed struct `rob_entry_t` {state, dest, value}.
- No sub-module. The entry array, pointer logic and commit register all live in `tomasulo_rob`.

## Test plan
- **Reset then single instruction.**
  - Stimulus: reset, allocate dest=5, then CDB tag=0 data=0x00AA.
  - Response: `alloc_tag` = 0; the cycle after the CDB edge, `commit_valid` = 1, `commit_dest` = 5, `commit_data` = 0x00AA, `commit_tag` = 0; then `count` = 0.
- **Out-of-order completion.**
  - Stimulus: allocate tags 0, 1, 2; CDB writes tag 2, then 1, then 0.
  - Response: no commit until tag 0 is written; then commits of tags 0, 1, 2 on three consecutive cycles.
- **Full and wrap-around.**
  - Stimulus: allocate 8 entries.
  - Response: `count` = 8 and `alloc_ready` = 0. Complete and commit tag 0; `alloc_ready` returns to 1 and the next `alloc_tag` = 0 (wrap).
- **Bypass and ignore rules.**
  - Stimulus: `rd_tag` = 3 while entry 3 is BUSY and a CDB broadcast to tag 3 with 0x1234 is on the bus.
  - Response: `rd_ready` = 1, `rd_data` = 0x1234.
  - A second CDB write to tag 3 leaves its `value` at 0x1234.
- **Flush and reset mid-operation.**
  - Stimulus: with 4 in-flight entries (two DONE), assert `flush` on an edge where the head would commit.
  - Response: no commit pulse; `count` = 0, `alloc_tag` = 0.
  - Repeat the stimulus with `reset`: same result.
